proc_ctrl_unit: RTL and testbench

Microprogrammed-free, hardwired control FSM for the 8-bit matrix processor datapath. It fetches instruction bytes from IROM, decodes them, and drives every datapath control line:
- register write enables, increments and clears;
- bus mux and comparator mux selects;
- ALU opcode and memory strobes.

It sits beside the datapath at processor top level. The only datapath status it consumes is the comparator zero flag.

---
 rtl/proc_ctrl_unit.sv | 150 +++++++++++++++
 tb/tb_proc_ctrl_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_unit.sv
// proc_ctrl_unit: hardwired control FSM for the 8-bit matrix processor.
// Fetches instruction bytes from IROM, decodes them and drives every
// datapath control line. Outputs are a decode of state and IR. The only
// exception is the JNZ PC write in JP, which follows zFlag combinationally.
module proc_ctrl_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] instr,
    input  logic             zFlag,
    output logic [15:0]      wEN,
    output logic [5:0]       INC,
    output logic [4:0]       RST,
    output logic [2:0]       compMUX,
    output logic [2:0]       aluOP,
    output logic [3:0]       busMUX,
    output logic             selAR,
    output logic             memREAD,
    output logic             memWRITE,
    output logic             iROMREAD,
    output logic             halted
);

    localparam logic [3:0] OP_LDAR  = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_MOVTO = 4'h5;
    localparam logic [3:0] OP_MOVFR = 4'h6;
    localparam logic [3:0] OP_ALU   = 4'h7;
    localparam logic [3:0] OP_INCR  = 4'h8;
    localparam logic [3:0] OP_CLR   = 4'h9;
    localparam logic [3:0] OP_JNZ   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_EX, S_O1, S_O2, S_JP, S_M2, S_HALT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ir;
    logic [3:0]       opc;
    logic [3:0]       opd;

    // The opcode for decode in EX comes from IR. IR is loaded in F2, so
    // EX always sees the byte fetched for this instruction.
    assign opc = ir[WIDTH-1:WIDTH-4];
    assign opd = ir[3:0];

    // State sequencing and IR capture. Reset returns to IDLE asynchronously.
    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_F1;
                S_F1:   state <= S_F2;
                S_F2: begin
                    ir    <= instr;
                    state <= S_EX;
                end
                S_EX: begin
                    case (opc)
                        OP_LDAR, OP_JMP, OP_JNZ: state <= S_O1;
                        OP_LOAD:                 state <= S_M2;
                        OP_HALT:                 state <= S_HALT;
                        default:                 state <= S_F1;
                    endcase
                end
                S_O1:   state <= S_O2;
                S_O2:   state <= (opc == OP_LDAR) ? S_F1 : S_JP;
                S_JP:   state <= S_F1;
                S_M2:   state <= S_F1;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control line decode from state and IR. zFlag is used only in JP for JNZ.
    always_comb begin
        wEN      = '0;
        INC      = '0;
        RST      = '0;
        compMUX  = 3'b001;
        aluOP    = '0;
        busMUX   = '0;
        selAR    = 1'b0;
        memREAD  = 1'b0;
        memWRITE = 1'b0;
        iROMREAD = 1'b0;
        halted   = 1'b0;
        case (state)
            S_IDLE: compMUX = 3'b000;
            S_F1, S_O1: iROMREAD = 1'b1;
            S_F2:   INC[5] = 1'b1;
            S_EX: begin
                case (opc)
                    OP_LOAD:  memREAD  = 1'b1;
                    OP_STORE: memWRITE = 1'b1;
                    OP_MOVTO: begin
                        busMUX = 4'd2;
                        // These destinations are unused or have no load path.
                        case (opd)
                            4'd0, 4'd4, 4'd5, 4'd6, 4'd14, 4'd15: ;
                            default: wEN[opd] = 1'b1;
                        endcase
                    end
                    OP_MOVFR: begin
                        busMUX = opd;
                        if (opd != 4'd15) wEN[12] = 1'b1;
                    end
                    OP_ALU: begin
                        aluOP  = opd[2:0];
                        busMUX = 4'd2;
                        wEN[0] = 1'b1;
                    end
                    OP_INCR: if (opd <= 4'd5) INC[opd[2:0]] = 1'b1;
                    OP_CLR:  if (opd <= 4'd2) RST[opd[2:0]] = 1'b1;
                    default: ;
                endcase
            end
            S_O2: begin
                selAR   = 1'b1;
                wEN[13] = 1'b1;
                INC[5]  = 1'b1;
            end
            S_JP: begin
                if (opc == OP_JNZ) begin
                    compMUX = opd[2:0];
                    wEN[15] = ~zFlag;
                end else begin
                    wEN[15] = 1'b1;
                end
            end
            S_M2: begin
                busMUX  = 4'd0;
                wEN[12] = 1'b1;
            end
            S_HALT: begin
                compMUX = 3'b000;
                halted  = 1'b1;
            end
            default: compMUX = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Directed-vector bench for proc_ctrl_unit. All outputs are packed into one
// vector and compared once per cycle, 1-3 ns after the rising edge.
module tb_proc_ctrl_unit;

    logic        Clk;
    logic        RSTn;
    logic [7:0]  instr;
    logic        zFlag;
    logic [15:0] wEN;
    logic [5:0]  INC;
    logic [4:0]  RST;
    logic [2:0]  compMUX;
    logic [2:0]  aluOP;
    logic [3:0]  busMUX;
    logic        selAR, memREAD, memWRITE, iROMREAD, halted;

    int n_chk  = 0;
    int n_fail = 0;

    proc_ctrl_unit #(.WIDTH(8)) dut (
        .Clk(Clk), .RSTn(RSTn), .instr(instr), .zFlag(zFlag),
        .wEN(wEN), .INC(INC), .RST(RST), .compMUX(compMUX), .aluOP(aluOP),
        .busMUX(busMUX), .selAR(selAR), .memREAD(memREAD),
        .memWRITE(memWRITE), .iROMREAD(iROMREAD), .halted(halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {wEN, INC, RST, compMUX, aluOP, busMUX, selAR, memREAD, memWRITE, iROMREAD, halted}
    logic [41:0] obs;
    assign obs = {wEN, INC, RST, compMUX, aluOP, busMUX,
                  selAR, memREAD, memWRITE, iROMREAD, halted};

    function automatic logic [41:0] ov(input logic [15:0] w, input logic [5:0] i,
                                       input logic [4:0] r, input logic [2:0] c,
                                       input logic [2:0] a, input logic [3:0] b,
                                       input logic [4:0] s);
        return {w, i, r, c, a, b, s};
    endfunction

    localparam logic [41:0] ZV  = 42'd0;
    localparam logic [41:0] F1V = {16'h0, 6'h00, 5'h0, 3'b001, 3'd0, 4'd0, 5'b00010};
    localparam logic [41:0] F2V = {16'h0, 6'h20, 5'h0, 3'b001, 3'd0, 4'd0, 5'b00000};
    localparam logic [41:0] EXV = {16'h0, 6'h00, 5'h0, 3'b001, 3'd0, 4'd0, 5'b00000};
    localparam logic [41:0] O2V = {16'h2000, 6'h20, 5'h0, 3'b001, 3'd0, 4'd0, 5'b10000};

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            n_chk++;
            if (obs !== ZV) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d got %h exp %h", k, obs, ZV);
            end
        end
        RSTn = 1'b1;
        #1;
        n_chk++;
        if (obs !== ZV) begin
            n_fail++;
            $display("FAIL reset_idle got %h exp %h", obs, ZV);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_nop_store();
        logic [41:0] e [6];
        logic [7:0]  in [6];
        e  = '{F1V, F2V, EXV, F1V, F2V, ov(16'h0, 6'h0, 5'h0, 3'b001, 3'd0, 4'd0, 5'b00100)};
        in = '{8'h00, 8'h00, 8'h00, 8'h30, 8'h30, 8'h00};
        for (int k = 0; k < 6; k++) begin
            instr = in[k];
            #1;
            n_chk++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL nop_store cyc%0d got %h exp %h", k, obs, e[k]);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_ldar_load();
        logic [41:0] e [9];
        logic [7:0]  in [9];
        e  = '{F1V, F2V, EXV, F1V, O2V, F1V, F2V,
               ov(16'h0, 6'h0, 5'h0, 3'b001, 3'd0, 4'd0, 5'b01000),
               ov(16'h1000, 6'h0, 5'h0, 3'b001, 3'd0, 4'd0, 5'b00000)};
        in = '{8'h10, 8'h10, 8'h10, 8'h42, 8'h42, 8'h20, 8'h20, 8'h20, 8'h20};
        for (int k = 0; k < 9; k++) begin
            instr = in[k];
            #1;
            n_chk++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL ldar_load cyc%0d got %h exp %h", k, obs, e[k]);
            end
            @(posedge Clk); #1;
        end
    endtask

    // JNZ taken, JNZ not taken, then JMP. zFlag is held opposite outside JP
    // so that any use of it in another state is exposed.
    task automatic test_jnz();
        logic [41:0] e [19];
        logic [7:0]  in [19];
        logic        zf [19];
        e  = '{F1V, F2V, EXV, F1V, O2V, ov(16'h8000, 6'h0, 5'h0, 3'b100, 3'd0, 4'd0, 5'b0),
               F1V, F2V, EXV, F1V, O2V, ov(16'h0000, 6'h0, 5'h0, 3'b100, 3'd0, 4'd0, 5'b0),
               F1V, F2V, EXV, F1V, O2V, ov(16'h8000, 6'h0, 5'h0, 3'b001, 3'd0, 4'd0, 5'b0),
               F1V};
        in = '{8'hA4, 8'hA4, 8'hA4, 8'h10, 8'h10, 8'h10,
               8'hA4, 8'hA4, 8'hA4, 8'h20, 8'h20, 8'h20,
               8'hB0, 8'hB0, 8'hB0, 8'h30, 8'h30, 8'h30, 8'h00};
        zf = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 19; k++) begin
            instr = in[k];
            zFlag = zf[k];
            #1;
            n_chk++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL jump cyc%0d got %h exp %h", k, obs, e[k]);
            end
            if (k < 18) begin
                @(posedge Clk); #1;
            end
        end
        zFlag = 1'b0;
    endtask

    task automatic test_single_cycle_ops();
        logic [7:0]  op [8];
        logic [41:0] ex [8];
        logic [41:0] want;
        op = '{8'h57, 8'h6E, 8'h73, 8'h81, 8'h92, 8'h5F, 8'h6F, 8'h86};
        ex = '{ov(16'h0080, 6'h00, 5'h0, 3'b001, 3'd0, 4'd2,  5'b0),
               ov(16'h1000, 6'h00, 5'h0, 3'b001, 3'd0, 4'd14, 5'b0),
               ov(16'h0001, 6'h00, 5'h0, 3'b001, 3'd3, 4'd2,  5'b0),
               ov(16'h0000, 6'h02, 5'h0, 3'b001, 3'd0, 4'd0,  5'b0),
               ov(16'h0000, 6'h00, 5'h4, 3'b001, 3'd0, 4'd0,  5'b0),
               ov(16'h0000, 6'h00, 5'h0, 3'b001, 3'd0, 4'd2,  5'b0),
               ov(16'h0000, 6'h00, 5'h0, 3'b001, 3'd0, 4'd15, 5'b0),
               EXV};
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 3; c++) begin
                instr = op[i];
                want  = (c == 0) ? F1V : (c == 1) ? F2V : ex[i];
                #1;
                n_chk++;
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL op_%h cyc%0d got %h exp %h", op[i], c, obs, want);
                end
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic test_halt();
        logic [41:0] e [6];
        e = '{F1V, F2V, EXV,
              ov(16'h0, 6'h0, 5'h0, 3'b000, 3'd0, 4'd0, 5'b00001),
              ov(16'h0, 6'h0, 5'h0, 3'b000, 3'd0, 4'd0, 5'b00001),
              ov(16'h0, 6'h0, 5'h0, 3'b000, 3'd0, 4'd0, 5'b00001)};
        for (int k = 0; k < 6; k++) begin
            instr = (k < 3) ? 8'hF0 : 8'h30;
            #1;
            n_chk++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL halt cyc%0d got %h exp %h", k, obs, e[k]);
            end
            @(posedge Clk); #1;
        end
        RSTn = 1'b0;
        #1;
        n_chk++;
        if (obs !== ZV) begin
            n_fail++;
            $display("FAIL halt_reset got %h exp %h", obs, ZV);
        end
        @(posedge Clk); #1;
        RSTn = 1'b1;
        #1;
        n_chk++;
        if (obs !== ZV) begin
            n_fail++;
            $display("FAIL halt_idle got %h exp %h", obs, ZV);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_store();
        logic [41:0] e [3];
        e = '{F1V, F2V, ov(16'h0, 6'h0, 5'h0, 3'b001, 3'd0, 4'd0, 5'b00100)};
        for (int k = 0; k < 3; k++) begin
            instr = 8'h30;
            #1;
            n_chk++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL mid_store cyc%0d got %h exp %h", k, obs, e[k]);
            end
            if (k < 2) begin
                @(posedge Clk); #1;
            end
        end
        RSTn = 1'b0;
        #1;
        n_chk++;
        if (memWRITE !== 1'b0 || obs !== ZV) begin
            n_fail++;
            $display("FAIL mid_store_drop got %h exp %h", obs, ZV);
        end
        @(posedge Clk); #1;
        RSTn = 1'b1;
        #1;
        n_chk++;
        if (obs !== ZV) begin
            n_fail++;
            $display("FAIL mid_store_idle got %h exp %h", obs, ZV);
        end
        @(posedge Clk); #1;
        #1;
        n_chk++;
        if (obs !== F1V) begin
            n_fail++;
            $display("FAIL mid_store_refetch got %h exp %h", obs, F1V);
        end
    endtask

    initial begin
        RSTn  = 1'b0;
        instr = 8'h00;
        zFlag = 1'b0;
        test_reset();
        test_nop_store();
        test_ldar_load();
        test_jnz();
        test_single_cycle_ops();
        test_halt();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
